sys_arr_stream_feeder: RTL
==========================

# sys_arr_stream_feeder

Transmit-side feeder for the systolic array input stream. It holds operand matrices A (M×N) and B (N×K, K=M) in an internal operand buffer loaded through a word-write port. On `start`, it emits the interleaved A-column/B-row beats that `sys_array` consumes on its input stream, using a valid/ready handshake. It sits between the host/memory side and `sys_array` and replaces the behavioural stream driver used in simulation.

## Interface
Parameters:
- `M`, 16, rows of A and columns of B (K = M).
- `N`, 4, inner dimension.
- `BW`, 16, words per beat. Power of 2, ≥2. M must be a multiple of BW/2 (elaboration `$error` otherwise).

Ports:
- `CLK`  in  1  clock. All logic on rising edge.
- `RST`  in  1  reset. Synchronous, active-high.
- `ld_en`  in  1  operand write strobe.
- `ld_sel`  in  1  0 = A buffer, 1 = B buffer.
- `ld_addr`  in  $clog2(max(M*N,N*K))  row-major word index.
- `ld_data`  in  32  IEEE-754 single (`word_t`).
- `start`  in  1  begin streaming (pulse).
- `str_data`  out  BW×32 (`word_t [BW-1:0]`)  beat payload.
- `str_valid`  out  1  beat valid.
- `str_ready`  in  1  downstream accept.
- `busy`  out  1  high in STREAM.
- `done`  out  1  one-cycle pulse after last beat accepted.

## Operation
- FSM `feeder_state_t`: IDLE → STREAM → DONE → IDLE.
- IDLE:
  - `ld_en` writes `ld_data` to A[`ld_addr`] or B[`ld_addr`] (per `ld_sel`). Out-of-range address is dropped.
  - `start` loads beat 0 into the output register, sets `str_valid`, and moves to STREAM.
- Counters: `outer` (0..M-BW/2, step BW/2) and `inner` (0..N-1). Both are 0 at start.
- Beat payload, for i in 0..BW/2-1, with col = N-1-inner:
  - lane 2i = A[(outer+i)*N + col]
  - lane 2i+1 = B[col*K + outer+i]
- Advance rule (on handshake):
  - `outer` += BW/2.
  - On wrap to 0, `inner` += 1.
- Total beats = N·M/(BW/2).
- STREAM: on `str_valid && str_ready`:
  - If more beats remain, register the next beat (valid stays high).
  - Otherwise drop valid and go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` is ignored outside IDLE. `ld_en` is ignored outside IDLE (buffer unchanged).
- Simultaneous `start` and `ld_en` in IDLE: the write commits and streaming starts. The beat-0 read reflects pre-write contents (read-before-write).
- Buffer contents are not cleared by reset.

## Timing
- Reset values: `str_valid`=0, `str_data`='0, `busy`=0, `done`=0, counters 0, state IDLE.
- `start` sampled at edge t → `str_valid`=1, beat 0 on `str_data` from t+1.
- Output is fully registered. `str_data` is stable while `str_valid && !str_ready` (AXI rule). Valid never drops without a handshake.
- Back-to-back: one beat per cycle while `str_ready`=1.
- Last handshake at edge u → `str_valid`=0 and `done`=1 in cycle u+1, `busy`=0 from u+2.
- Start-to-done with no backpressure = beats+1 cycles.
- `RST` mid-stream: all outputs return to reset values on the next edge and the stream is abandoned. Downstream must also be reset.

## Configuration
- Macro `FEEDER_GAP_EN`.
- Defined:
  - Extra input `gap_cycles` [7:0], sampled on `start`.
  - After each accepted beat except the last, `str_valid` is held low for `gap_cycles` cycles, then the next beat is presented. This models memory latency.
  - Additional counter and GAP state inside STREAM.
- Undefined: port absent and beats are back-to-back (equivalent to `gap_cycles`=0).

## Structure
- Add to `dsp_sys_arr_pkg`:
  - `feeder_state_t` (IDLE, STREAM, GAP, DONE).
  - `localparam`-style function `feeder_num_beats(M,N,BW)`.
- Reuse `word_t` from the package.
- Sub-module `sys_arr_operand_buf`: two register-file banks (A, B) with one write port and a combinational wide read of BW/2 A words plus BW/2 B words, indexed by (`outer`,`inner`).
- The top level holds the FSM, counters and output register.

## Test plan
- M=8,N=4,BW=16, A[i*4+j]=i*4+j+1, B[i*8+j]=j*4+i+1. Load both, pulse `start` → 4 beats.
  - Beat 0: lane0=4.0 (0x40800000), lane1=4.0, lane2=8.0, lane3=8.0.
  - Beat 3: lane0=1.0.
  - `done` in cycle 5 after start.
- Same setup, `str_ready` low 5 cycles on beat 1 → `str_data`/`str_valid` constant throughout. Beat 2 appears the cycle after `str_ready` rises.
- `start` pulsed again during STREAM, plus `ld_en` to A[0]=99.0 → no restart, no buffer change. Rerun after `done` shows lane0 of beat 3 = 1.0.
- `RST` high at beat 2 → next cycle `str_valid`=0, `busy`=0. A new `start` replays from beat 0 with identical data.
- `start` and `ld_en` (A[3]=7.0) in the same cycle → beat 0 lane0=4.0. Second run lane0=7.0.
- With `FEEDER_GAP_EN`, `gap_cycles`=2, `str_ready`=1 → valid pattern 1,0,0,1,0,0,1,0,0,1. `done` 11 cycles after start.

Source files
------------

// File: rtl/dsp_sys_arr_pkg.sv
// ---------------------------------------------------------------------------
// dsp_sys_arr_pkg
// Shared types and helpers for the systolic-array datapath and its feeders.
//   word_t             : one IEEE-754 single-precision operand word
//   feeder_state_t     : stream feeder FSM states
//   feeder_num_beats() : beats needed to stream an MxN / NxM operand pair
//   cnt_width()        : counter width for a 0..n-1 range (min 1 bit)
// ---------------------------------------------------------------------------
package dsp_sys_arr_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        DONE
    } feeder_state_t;

    // Each beat carries BW/2 A words and BW/2 B words, so one inner step
    // over all M rows takes M/(BW/2) beats, repeated N times.
    function automatic int feeder_num_beats(input int m, input int n, input int bw);
        return (n * m) / (bw / 2);
    endfunction

    // Width of a counter that must hold 0..n-1; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_arr_operand_buf.sv
// ---------------------------------------------------------------------------
// sys_arr_operand_buf
// Two register-file banks holding operand matrices A (MxN) and B (NxM), both
// row-major. One shared write port, plus a combinational wide read returning
// the BW/2 A words and BW/2 B words of the beat selected by (outer, inner).
// Contents are never reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_sel   in   0 = A bank, 1 = B bank
//   wr_addr  in   row-major word index; out-of-range writes are dropped
//   wr_data  in   word to write
//   outer    in   first A row / B column of the beat
//   inner    in   inner step; the column/row used is N-1-inner
//   rd_a     out  A[(outer+i)*N + col], i = 0..BW/2-1
//   rd_b     out  B[col*M + outer+i],   i = 0..BW/2-1
// ---------------------------------------------------------------------------
module sys_arr_operand_buf
    import dsp_sys_arr_pkg::*;
#(
    parameter int M  = 16,
    parameter int N  = 4,
    parameter int BW = 16
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(M*N)-1:0]        wr_addr,
    input  word_t                         wr_data,
    input  logic [cnt_width(M)-1:0]       outer,
    input  logic [cnt_width(N)-1:0]       inner,
    output word_t [BW/2-1:0]              rd_a,
    output word_t [BW/2-1:0]              rd_b
);

    localparam int DEPTH = M * N;
    localparam int AW    = $clog2(M * N);
    localparam int IW    = cnt_width(N);

    word_t            a_bank_q [DEPTH];
    word_t            b_bank_q [DEPTH];
    logic             wr_ok;
    logic [IW-1:0]    col;

    // Only a non-power-of-two depth leaves address codes with no backing word.
    if ((1 << AW) > DEPTH) begin : g_range_chk
        assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);
    end else begin : g_range_full
        assign wr_ok = wr_en;
    end

    // Columns of A / rows of B are consumed last-to-first.
    assign col = IW'(N - 1) - inner;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel) begin
                b_bank_q[wr_addr] <= wr_data;
            end else begin
                a_bank_q[wr_addr] <= wr_data;
            end
        end
    end

    // Combinational gather of one beat; a same-cycle write is not visible yet.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < BW / 2; i++) begin
            rd_a[i] = a_bank_q[AW'((int'(outer) + i) * N + int'(col))];
            rd_b[i] = b_bank_q[AW'(int'(col) * M + int'(outer) + i)];
        end
    end

endmodule

// File: rtl/sys_arr_stream_feeder.sv
// ---------------------------------------------------------------------------
// sys_arr_stream_feeder
// Transmit-side feeder for the systolic array input stream. Operands are
// written into an internal buffer while idle; a start pulse then streams
// interleaved A-column / B-row beats over a valid/ready handshake.
// Optional macro FEEDER_GAP_EN inserts gap_cycles idle cycles between beats.
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   synchronous active-high reset
//   ld_en       in   operand write strobe (honoured only in IDLE)
//   ld_sel      in   0 = A buffer, 1 = B buffer
//   ld_addr     in   row-major word index
//   ld_data     in   operand word
//   start       in   begin streaming (honoured only in IDLE)
//   gap_cycles  in   idle cycles between beats (FEEDER_GAP_EN only)
//   str_data    out  registered beat payload, lane 2i = A, lane 2i+1 = B
//   str_valid   out  beat valid
//   str_ready   in   downstream accept
//   busy        out  high from the first beat until the done cycle ends
//   done        out  one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module sys_arr_stream_feeder
    import dsp_sys_arr_pkg::*;
#(
    parameter int M  = 16,
    parameter int N  = 4,
    parameter int BW = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ld_en,
    input  logic                      ld_sel,
    input  logic [$clog2(M*N)-1:0]    ld_addr,
    input  word_t                     ld_data,
    input  logic                      start,
`ifdef FEEDER_GAP_EN
    input  logic [7:0]                gap_cycles,
`endif
    output word_t [BW-1:0]            str_data,
    output logic                      str_valid,
    input  logic                      str_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int HALF      = BW / 2;
    localparam int OW        = cnt_width(M);
    localparam int IW        = cnt_width(N);
    localparam int NUM_BEATS = feeder_num_beats(M, N, BW);
    localparam logic [OW-1:0] OUTER_LAST = OW'(M - HALF);
    localparam logic [IW-1:0] INNER_LAST = IW'(N - 1);

    if (BW < 2 || (BW & (BW - 1)) != 0 || (M % HALF) != 0 || NUM_BEATS < 1) begin : g_param_err
        $error("sys_arr_stream_feeder: BW must be a power of 2 >= 2 and M a multiple of BW/2");
    end

    feeder_state_t       state_q, state_d;
    logic [OW-1:0]       outer_q, outer_d;
    logic [IW-1:0]       inner_q, inner_d;
    word_t [BW-1:0]      data_q, data_d;
    logic                valid_q, valid_d;
    logic                load_beat;
    logic                last_beat;
    word_t [HALF-1:0]    rd_a;
    word_t [HALF-1:0]    rd_b;
`ifdef FEEDER_GAP_EN
    logic [7:0]          gap_len_q, gap_len_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
`endif

    // The buffer is addressed with the next-state counters so the beat that
    // is about to be registered is already on the read port.
    sys_arr_operand_buf #(
        .M  (M),
        .N  (N),
        .BW (BW)
    ) u_buf (
        .clk     (CLK),
        .wr_en   (ld_en && (state_q == IDLE)),
        .wr_sel  (ld_sel),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .outer   (outer_d),
        .inner   (inner_d),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    assign last_beat = (outer_q == OUTER_LAST) && (inner_q == INNER_LAST);

    // Next-state, counter advance and output-register load.
    always_comb begin
        state_d   = state_q;
        outer_d   = outer_q;
        inner_d   = inner_q;
        data_d    = data_q;
        valid_d   = valid_q;
        load_beat = 1'b0;
`ifdef FEEDER_GAP_EN
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                outer_d = '0;
                inner_d = '0;
                if (start) begin
                    load_beat = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = STREAM;
`ifdef FEEDER_GAP_EN
                    gap_len_d = gap_cycles;
`endif
                end
            end
            STREAM: begin
                if (valid_q && str_ready) begin
                    if (last_beat) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        if (outer_q == OUTER_LAST) begin
                            outer_d = '0;
                            inner_d = inner_q + 1'b1;
                        end else begin
                            outer_d = outer_q + OW'(HALF);
                        end
`ifdef FEEDER_GAP_EN
                        if (gap_len_q == 8'd0) begin
                            load_beat = 1'b1;
                        end else begin
                            valid_d   = 1'b0;
                            gap_cnt_d = gap_len_q;
                            state_d   = GAP;
                        end
`else
                        load_beat = 1'b1;
`endif
                    end
                end
            end
            GAP: begin
`ifdef FEEDER_GAP_EN
                if (gap_cnt_q <= 8'd1) begin
                    load_beat = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = STREAM;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                outer_d = '0;
                inner_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load_beat) begin
            for (int i = 0; i < HALF; i++) begin
                data_d[2*i]   = rd_a[i];
                data_d[2*i+1] = rd_b[i];
            end
        end
    end

    // State, counters and the registered output beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            outer_q   <= '0;
            inner_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
`ifdef FEEDER_GAP_EN
            gap_len_q <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            outer_q   <= outer_d;
            inner_q   <= inner_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
`ifdef FEEDER_GAP_EN
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign str_data  = data_q;
    assign str_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
